obi_slave_rr_arbiter: RTL

- Shares one system-crossbar slave port (e.g. MEMORY_RAM0 bank) between NMASTER OBI requesters (cores 0-2 instr/data, external master) using round-robin arbitration.
- Tracks outstanding transactions in an ID FIFO so every rvalid/rdata is routed back to the master that issued it, in order.
- Sits between the crossbar's per-slave demux outputs and the slave memory/peripheral.

---
 rtl/obi_slave_rr_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/obi_slave_rr_arbiter.sv
// Round-robin arbiter sharing one OBI slave port between NMASTER requesters, with an ID FIFO routing responses back in order.
// Optional conflict counter output enabled by defining OBI_ARB_PERF_CNT_EN.
module obi_slave_rr_arbiter #(
    parameter int unsigned NMASTER         = 7,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned IDW             = $clog2(NMASTER)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NMASTER-1:0]      master_req_i,
    input  logic [NMASTER*32-1:0]   master_addr_i,
    input  logic [NMASTER-1:0]      master_we_i,
    input  logic [NMASTER*4-1:0]    master_be_i,
    input  logic [NMASTER*32-1:0]   master_wdata_i,
    output logic [NMASTER-1:0]      master_gnt_o,
    output logic [NMASTER-1:0]      master_rvalid_o,
    output logic [31:0]             master_rdata_o,
    output logic                    slave_req_o,
    output logic [31:0]             slave_addr_o,
    output logic                    slave_we_o,
    output logic [3:0]              slave_be_o,
    output logic [31:0]             slave_wdata_o,
    input  logic                    slave_gnt_i,
    input  logic                    slave_rvalid_i,
    input  logic [31:0]             slave_rdata_i,
    output logic                    busy_o,
    output logic                    rsp_err_o
`ifdef OBI_ARB_PERF_CNT_EN
    ,
    output logic [15:0]             conflict_cnt_o
`endif
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]  MAX_CNT   = CW'(MAX_OUTSTANDING);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NMASTER - 1);
    localparam logic [PW-1:0]  LAST_SLOT = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } lock_e;

    lock_e           lock_d, lock_q;
    logic [IDW-1:0]  locked_id_d, locked_id_q;
    logic [IDW-1:0]  ptr_d, ptr_q;
    logic [CW-1:0]   count_d, count_q;
    logic [PW-1:0]   wr_ptr_d, wr_ptr_q;
    logic [PW-1:0]   rd_ptr_d, rd_ptr_q;
    logic [IDW-1:0]  fifo_d [MAX_OUTSTANDING];
    logic [IDW-1:0]  fifo_q [MAX_OUTSTANDING];
    logic            rsp_err_d, rsp_err_q;

    logic [IDW-1:0]  rr_id;
    logic [IDW-1:0]  sel_id;
    logic [IDW-1:0]  head_id;
    logic            fifo_full;
    logic            handshake;
    logic            push;
    logic            pop;

    // First requester at or after the round-robin pointer, wrapping past NMASTER-1.
    always_comb begin
        int unsigned cand;
        logic        found;
        rr_id = ptr_q;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NMASTER; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NMASTER) begin
                cand = cand - NMASTER;
            end
            if (!found && master_req_i[IDW'(cand)]) begin
                rr_id = IDW'(cand);
                found = 1'b1;
            end
        end
    end

    assign sel_id    = (lock_q == ARB_LOCKED) ? locked_id_q : rr_id;
    assign fifo_full = (count_q == MAX_CNT);
    assign head_id   = fifo_q[rd_ptr_q];

    always_comb begin
        slave_req_o     = master_req_i[sel_id] & ~fifo_full;
        handshake       = slave_req_o & slave_gnt_i;
        push            = handshake;
        pop             = slave_rvalid_i & (count_q != '0);
        slave_addr_o    = '0;
        slave_we_o      = 1'b0;
        slave_be_o      = '0;
        slave_wdata_o   = '0;
        master_gnt_o    = '0;
        master_rvalid_o = '0;
        master_rdata_o  = pop ? slave_rdata_i : '0;
        for (int unsigned i = 0; i < NMASTER; i++) begin
            if (slave_req_o && (sel_id == IDW'(i))) begin
                slave_addr_o  = master_addr_i[i*32 +: 32];
                slave_we_o    = master_we_i[i];
                slave_be_o    = master_be_i[i*4 +: 4];
                slave_wdata_o = master_wdata_i[i*32 +: 32];
            end
            master_gnt_o[i]    = handshake && (sel_id == IDW'(i));
            master_rvalid_o[i] = pop && (head_id == IDW'(i));
        end
    end

    always_comb begin
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        ptr_d       = ptr_q;
        if (handshake) begin
            lock_d = ARB_FREE;
            ptr_d  = (sel_id == LAST_ID) ? '0 : sel_id + 1'b1;
        end else if (slave_req_o) begin
            lock_d      = ARB_LOCKED;
            locked_id_d = sel_id;
        end
    end

    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rsp_err_d = rsp_err_q | (slave_rvalid_i & (count_q == '0));
        if (push) begin
            fifo_d[wr_ptr_q] = sel_id;
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q      <= ARB_FREE;
            locked_id_q <= '0;
            ptr_q       <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_q      <= '{default: '0};
            rsp_err_q   <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_q      <= fifo_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign busy_o    = (count_q != '0);
    assign rsp_err_o = rsp_err_q;

`ifdef OBI_ARB_PERF_CNT_EN
    logic [15:0]        conflict_cnt_d, conflict_cnt_q;
    logic [NMASTER-1:0] other_req;
    logic               multi_req;

    always_comb begin
        other_req = master_req_i;
        for (int unsigned i = 0; i < NMASTER; i++) begin
            if (sel_id == IDW'(i)) begin
                other_req[i] = 1'b0;
            end
        end
        // x & (x-1) is non-zero exactly when more than one bit is set.
        multi_req      = |(master_req_i & (master_req_i - 1'b1));
        conflict_cnt_d = conflict_cnt_q;
        if (((multi_req && (lock_q == ARB_FREE)) || (|other_req)) && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule
